// File: rtl/image_resize_line_reader.sv
// Line-buffer read side for nearest-neighbour horizontal resize.
// Walks one source line at a fixed-point step and streams dst_len pixels.
//
// Ports:
//   rd_clk, rd_rst_n             clock and async active-low reset
//   start, base_addr, src_len,   line request, latched when idle
//   dst_len, step
//   busy, done                   line in progress / end-of-line pulse
//   ram_rd_addr, ram_rd_data     SDP RAM read port (1-cycle latency)
//   m_valid, m_ready, m_data,    output pixel stream
//   m_last
module image_resize_line_reader #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 24,
    parameter int FRAC_WIDTH = 8,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                           rd_clk,
    input  logic                           rd_rst_n,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic [LEN_WIDTH-1:0]           src_len,
    input  logic [LEN_WIDTH-1:0]           dst_len,
    input  logic [ADDR_WIDTH+FRAC_WIDTH-1:0] step,
    output logic                           busy,
    output logic                           done,
    output logic [ADDR_WIDTH-1:0]          ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]          ram_rd_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic                           m_last
);

    localparam int SW = ADDR_WIDTH + FRAC_WIDTH;
    localparam int AW = SW + 1;
    localparam int IW = (ADDR_WIDTH + 1 > LEN_WIDTH) ? ADDR_WIDTH + 1 : LEN_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [LEN_WIDTH-1:0]    src_q, src_d;
    logic [LEN_WIDTH-1:0]    dst_q, dst_d;
    logic [SW-1:0]           step_q, step_d;
    logic [AW-1:0]           acc_q, acc_d;
    logic [LEN_WIDTH-1:0]    iss_q, iss_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    avld_q, avld_d;
    logic                    alast_q, alast_d;
    logic                    rvld_q, rvld_d;
    logic                    rlast_q, rlast_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH:0]     fifo_q [2];
    logic [DATA_WIDTH:0]     fifo_d [2];
    logic                    wp_q, wp_d;
    logic                    rp_q, rp_d;
    logic [1:0]              cnt_q, cnt_d;

    logic                    pop;
    logic                    push;
    logic [2:0]              occ;
    logic                    can_issue;
    logic [IW-1:0]           acc_int;
    logic [IW-1:0]           src_m1;
    logic [IW-1:0]           idx;
    logic [ADDR_WIDTH-1:0]   rd_addr_calc;
    logic [AW:0]             acc_sum;
    logic [AW-1:0]           acc_next;
    logic [LEN_WIDTH-1:0]    iss_inc;

    assign m_valid     = (cnt_q != 2'd0);
    assign m_data      = fifo_q[rp_q][DATA_WIDTH-1:0];
    assign m_last      = fifo_q[rp_q][DATA_WIDTH];
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign ram_rd_addr = addr_q;

    assign pop  = m_valid & m_ready;
    // The returned word waits on ram_rd_data when the FIFO is full; the
    // address is held then, so the RAM keeps presenting the same word.
    assign push = rvld_q & ((cnt_q != 2'd2) | pop);

    // Address stage + data stage + FIFO may hold at most three beats in total;
    // that bound makes a waiting data-stage word impossible while a newer
    // address is on the bus, and still allows one read per cycle.
    assign occ       = 3'(cnt_q) + 3'(avld_q) + 3'(rvld_q) - 3'(pop);
    assign can_issue = (occ < 3'd3);

    assign acc_int      = IW'(acc_q >> FRAC_WIDTH);
    assign src_m1       = IW'(src_q) - IW'(1);
    assign idx          = (acc_int < src_m1) ? acc_int : src_m1;
    assign rd_addr_calc = base_q + ADDR_WIDTH'(idx);
    assign acc_sum      = {1'b0, acc_q} + (AW+1)'(step_q);
    assign acc_next     = acc_sum[AW] ? '1 : acc_sum[AW-1:0];
    assign iss_inc      = iss_q + LEN_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        src_d   = src_q;
        dst_d   = dst_q;
        step_d  = step_q;
        acc_d   = acc_q;
        iss_d   = iss_q;
        addr_d  = addr_q;
        avld_d  = 1'b0;
        alast_d = 1'b0;
        done_d  = 1'b0;
        fifo_d  = fifo_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        cnt_d   = cnt_q + 2'(push) - 2'(pop);
        rvld_d  = avld_q | (rvld_q & ~push);
        rlast_d = avld_q ? alast_q : rlast_q;

        if (pop) begin
            rp_d = ~rp_q;
        end
        if (push) begin
            fifo_d[wp_q] = {rlast_q, ram_rd_data};
            wp_d         = ~wp_q;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d = base_addr;
                    src_d  = src_len;
                    dst_d  = dst_len;
                    step_d = step;
                    if (dst_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // First read goes out on the start edge (acc = 0).
                        addr_d  = base_addr;
                        acc_d   = AW'(step);
                        iss_d   = LEN_WIDTH'(1);
                        avld_d  = 1'b1;
                        alast_d = (dst_len == LEN_WIDTH'(1));
                        state_d = alast_d ? S_DRAIN : S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (can_issue) begin
                    addr_d  = rd_addr_calc;
                    acc_d   = acc_next;
                    iss_d   = iss_inc;
                    avld_d  = 1'b1;
                    alast_d = (iss_inc == dst_q);
                    if (alast_d) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop & m_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            step_q  <= '0;
            acc_q   <= '0;
            iss_q   <= '0;
            addr_q  <= '0;
            avld_q  <= 1'b0;
            alast_q <= 1'b0;
            rvld_q  <= 1'b0;
            rlast_q <= 1'b0;
            done_q  <= 1'b0;
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
            cnt_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            iss_q   <= iss_d;
            addr_q  <= addr_d;
            avld_q  <= avld_d;
            alast_q <= alast_d;
            rvld_q  <= rvld_d;
            rlast_q <= rlast_d;
            done_q  <= done_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

endmodule

// File: tb/tb_image_resize_line_reader.sv
// Scoreboard bench for image_resize_line_reader.
// Directed lines, backpressure, and control edge cases.
module tb_image_resize_line_reader;

    logic        rd_clk;
    logic        rd_rst_n;
    logic        start;
    logic [10:0] base_addr;
    logic [11:0] src_len;
    logic [11:0] dst_len;
    logic [18:0] step;
    logic        busy;
    logic        done;
    logic [10:0] ram_rd_addr;
    logic [23:0] ram_rd_data;
    logic        m_valid;
    logic        m_ready;
    logic [23:0] m_data;
    logic        m_last;

    image_resize_line_reader dut (
        .rd_clk      (rd_clk),
        .rd_rst_n    (rd_rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .src_len     (src_len),
        .dst_len     (dst_len),
        .step        (step),
        .busy        (busy),
        .done        (done),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    // RAM model: word[a] = a, one cycle read latency, no enable.
    always @(posedge rd_clk) ram_rd_data <= 24'(ram_rd_addr);

    logic [24:0] exp_q [$];
    int  tb_cmp, tb_fail;
    int  mon_cmp, mon_fail;
    int  done_seen;
    bit  done_chk;
    bit  rdy_rand;

    bit          stall_prev;
    bit          last_hs_prev;
    logic [23:0] hold_data;
    logic        hold_last;

    always @(negedge rd_clk) begin
        if (!rd_rst_n) begin
            stall_prev   = 1'b0;
            last_hs_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                mon_cmp++;
                if (!(m_valid && m_data == hold_data && m_last == hold_last)) begin
                    mon_fail++;
                    $display("FAIL stall_hold got v=%0b d=%0h l=%0b want v=1 d=%0h l=%0b",
                             m_valid, m_data, m_last, hold_data, hold_last);
                end
            end
            if (done_chk && (done || last_hs_prev)) begin
                mon_cmp++;
                if (done !== last_hs_prev) begin
                    mon_fail++;
                    $display("FAIL done_timing got %0b want %0b", done, last_hs_prev);
                end
            end
            if (done) done_seen++;
            if (m_valid && m_ready) begin
                mon_cmp++;
                if (exp_q.size() == 0) begin
                    mon_fail++;
                    $display("FAIL extra_beat got d=%0h l=%0b want no beat", m_data, m_last);
                end else begin
                    logic [24:0] e;
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin
                        mon_fail++;
                        $display("FAIL beat got d=%0h l=%0b want d=%0h l=%0b",
                                 m_data, m_last, e[23:0], e[24]);
                    end
                end
            end
            stall_prev   = m_valid && !m_ready;
            hold_data    = m_data;
            hold_last    = m_last;
            last_hs_prev = m_valid && m_ready && m_last;
        end
    end

    initial forever begin
        @(posedge rd_clk);
        #1;
        m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        tb_cmp++;
        if (got !== want) begin
            tb_fail++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic [23:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    // Start pulse; params are scrambled after the start edge.
    task automatic run_line(input logic [10:0] b, input logic [11:0] s,
                            input logic [11:0] d, input logic [18:0] st);
        @(posedge rd_clk);
        #1;
        base_addr = b;
        src_len   = s;
        dst_len   = d;
        step      = st;
        start     = 1'b1;
        @(posedge rd_clk);
        #1;
        start     = 1'b0;
        base_addr = 11'h555;
        src_len   = 12'd1;
        dst_len   = 12'd2;
        step      = 19'h7ffff;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n0;
        int c;
        n0 = done_seen;
        c  = 0;
        while (done_seen == n0 && c < budget) begin
            @(negedge rd_clk);
            c++;
        end
        chk({name, "_done_seen"}, 64'(done_seen - n0), 64'd1);
        chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    int          cyc_valid;
    logic [10:0] t4_addr [6];
    logic [23:0] t3_data [5];
    bit          saw_valid;

    initial begin
        tb_cmp    = 0;
        tb_fail   = 0;
        mon_cmp   = 0;
        mon_fail  = 0;
        done_seen = 0;
        done_chk  = 1'b1;
        rdy_rand  = 1'b0;
        rd_rst_n  = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        src_len   = '0;
        dst_len   = '0;
        step      = '0;
        m_ready   = 1'b1;
        t4_addr   = '{11'd2046, 11'd2047, 11'd0, 11'd1, 11'd1, 11'd1};
        t3_data   = '{24'd0, 24'd1, 24'd3, 24'd4, 24'd6};

        repeat (3) @(negedge rd_clk);
        chk("reset_outputs", {busy, done, ram_rd_addr, m_valid, m_data, m_last}, '0);
        rd_rst_n = 1'b1;
        repeat (2) @(negedge rd_clk);

        // 1) identity line with latency checks
        for (int i = 0; i < 8; i++) push_exp(24'(i), i == 7);
        run_line(11'd0, 12'd8, 12'd8, 19'h00100);
        @(negedge rd_clk);
        chk("t1_c1_busy", busy, 1'b1);
        chk("t1_c1_addr", ram_rd_addr, 11'd0);
        chk("t1_c1_valid", m_valid, 1'b0);
        @(negedge rd_clk);
        chk("t1_c2_valid", m_valid, 1'b0);
        @(negedge rd_clk);
        chk("t1_c3_valid", m_valid, 1'b1);
        chk("t1_c3_data", m_data, 24'd0);
        cyc_valid = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge rd_clk);
            if (m_valid) cyc_valid++;
        end
        chk("t1_consecutive", 64'(cyc_valid), 64'd7);
        wait_done("t1", 50);
        chk("t1_idle", busy, 1'b0);

        // 2) 2x upscale
        for (int i = 0; i < 16; i++) push_exp(24'(i / 2), i == 15);
        run_line(11'd0, 12'd8, 12'd16, 19'h00080);
        wait_done("t2", 100);

        // 3) downscale by 1.5
        for (int i = 0; i < 5; i++) push_exp(t3_data[i], i == 4);
        run_line(11'd0, 12'd8, 12'd5, 19'h00180);
        wait_done("t3", 100);

        // 4) clamp at line end and address wrap
        push_exp(24'd2046, 1'b0);
        push_exp(24'd2047, 1'b0);
        push_exp(24'd0, 1'b0);
        push_exp(24'd1, 1'b0);
        push_exp(24'd1, 1'b0);
        push_exp(24'd1, 1'b1);
        run_line(11'd2046, 12'd4, 12'd6, 19'h00100);
        for (int i = 0; i < 6; i++) begin
            @(negedge rd_clk);
            chk($sformatf("t4_addr%0d", i), ram_rd_addr, t4_addr[i]);
        end
        wait_done("t4", 100);

        // step = 0 repeats source pixel 0
        for (int i = 0; i < 4; i++) push_exp(24'd5, i == 3);
        run_line(11'd5, 12'd8, 12'd4, 19'h00000);
        wait_done("t_step0", 100);

        // 5) upscale under random backpressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 16; i++) push_exp(24'(i / 2), i == 15);
        run_line(11'd0, 12'd8, 12'd16, 19'h00080);
        wait_done("t5", 600);
        rdy_rand = 1'b0;
        repeat (2) @(negedge rd_clk);

        // 6a) dst_len = 0
        done_chk = 1'b0;
        run_line(11'd0, 12'd8, 12'd0, 19'h00100);
        @(negedge rd_clk);
        chk("t6a_done", done, 1'b1);
        chk("t6a_busy", busy, 1'b0);
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge rd_clk);
            if (m_valid || done) saw_valid = 1'b1;
        end
        chk("t6a_quiet", saw_valid, 1'b0);
        done_chk = 1'b1;

        // 6b) start while busy is ignored
        for (int i = 0; i < 8; i++) push_exp(24'(i), i == 7);
        run_line(11'd0, 12'd8, 12'd8, 19'h00100);
        @(posedge rd_clk);
        #1;
        base_addr = 11'd100;
        src_len   = 12'd8;
        dst_len   = 12'd3;
        step      = 19'h00100;
        start     = 1'b1;
        @(posedge rd_clk);
        #1;
        start     = 1'b0;
        wait_done("t6b", 100);
        repeat (20) @(negedge rd_clk);
        chk("t6b_idle", {busy, m_valid}, 2'b00);
        chk("t6b_queue", 64'(exp_q.size()), 64'd0);

        // 6c) reset mid-line
        for (int i = 0; i < 16; i++) push_exp(24'(i / 2), i == 15);
        run_line(11'd0, 12'd8, 12'd16, 19'h00080);
        repeat (5) @(negedge rd_clk);
        chk("t6c_pre_valid", m_valid, 1'b1);
        #2;
        rd_rst_n = 1'b0;
        #1;
        chk("t6c_rst_outputs", {busy, done, ram_rd_addr, m_valid, m_data, m_last}, '0);
        exp_q.delete();
        repeat (2) @(negedge rd_clk);
        rd_rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge rd_clk);
            if (done || busy || m_valid) saw_valid = 1'b1;
        end
        chk("t6c_no_done", saw_valid, 1'b0);

        // 6d) clean line after reset
        for (int i = 0; i < 5; i++) push_exp(t3_data[i], i == 4);
        run_line(11'd0, 12'd8, 12'd5, 19'h00180);
        wait_done("t6d", 100);

        repeat (3) @(negedge rd_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 tb_cmp + mon_cmp, tb_fail + mon_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
